// File: rtl/sipo_rx_pkg.sv
// Shared constants for the serial receive path (also used by the PISO side).
package sipo_rx_pkg;

    // Default word size of the serial link
    localparam int WIDTH_DEFAULT = 5;

    // Bit order on the wire: 1 = first serial bit is the word MSB
    localparam bit MSB_FIRST = 1'b1;

    // Bit-counter width for a given word size (never narrower than one bit)
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/rx_hold_reg.sv
// One-word valid/ready holding register with sticky overrun detection.
module rx_hold_reg #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overrun
);

    logic can_accept;

    // The slot is free if it is empty or its word is being consumed this cycle
    assign can_accept = !out_valid || out_ready;

    // Load a completed word, or retire the held word on a transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load && can_accept) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overrun: a dropped word sets it, and setting beats clearing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (load && !can_accept) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_5bit_rx.sv
// Serial-to-parallel receiver: shifts in bits, frames words, hands them off.
module sipo_5bit_rx
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             bit_en,
    input  logic             sync,
    input  logic             out_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overrun,
    output logic             busy
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_bit;
    logic             word_done;

    // Shift direction and first-bit placement follow the link bit order
    assign shifted   = MSB_FIRST ? {shreg[WIDTH-2:0], ser_in}
                                 : {ser_in, shreg[WIDTH-1:1]};
    assign first_bit = MSB_FIRST ? {{(WIDTH-1){1'b0}}, ser_in}
                                 : {ser_in, {(WIDTH-1){1'b0}}};

    // A word finishes when its last bit arrives outside a sync realign
    assign word_done = bit_en && !sync && (bit_cnt == LAST_CNT);

    // Shift register and bit counter; sync restarts framing at this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (sync) begin
            if (bit_en) begin
                shreg   <= first_bit;
                bit_cnt <= ONE_CNT;
            end else begin
                shreg   <= '0;
                bit_cnt <= '0;
            end
        end else if (bit_en) begin
            shreg   <= shifted;
            bit_cnt <= (bit_cnt == LAST_CNT) ? '0 : bit_cnt + ONE_CNT;
        end
    end

    assign busy = (bit_cnt != '0);

    rx_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (word_done),
        .load_data (shifted),
        .out_ready (out_ready),
        .ovr_clr   (ovr_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_sipo_5bit_rx.sv
// Randomized and directed bench for sipo_5bit_rx against a bit-queue model.
module tb_sipo_5bit_rx;

    localparam int WIDTH = 5;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             ser_in    = 1'b0;
    logic             bit_en    = 1'b0;
    logic             sync      = 1'b0;
    logic             out_ready = 1'b0;
    logic             ovr_clr   = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             overrun;
    logic             busy;

    // Reference model: bits of the word in progress, plus the output slot
    int unsigned partial[$];
    int unsigned exp_data;
    bit          exp_valid;
    bit          exp_ovr;

    int vector_count     = 0;
    int miscompare_count = 0;

    sipo_5bit_rx #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_in    (ser_in),
        .bit_en    (bit_en),
        .sync      (sync),
        .out_ready (out_ready),
        .ovr_clr   (ovr_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int unsigned observed,
                               input int unsigned expected);
        vector_count++;
        if (observed != expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".data"},  out_data,  exp_data);
        checkOutput({tag, ".valid"}, out_valid, exp_valid);
        checkOutput({tag, ".ovr"},   overrun,   exp_ovr);
        checkOutput({tag, ".busy"},  busy,      (partial.size() != 0));
    endtask

    task automatic modelReset();
        partial.delete();
        exp_data  = 0;
        exp_valid = 0;
        exp_ovr   = 0;
    endtask

    // One clock edge of the model, from the inputs that were just driven
    task automatic modelStep(input bit s, input bit be, input bit sy,
                             input bit rdy, input bit oc);
        bit          complete = 0;
        bit          slot_free;
        int unsigned word = 0;
        if (sy) begin
            partial.delete();
            if (be) partial.push_back(s);
        end else if (be) begin
            partial.push_back(s);
            if (partial.size() == WIDTH) begin
                foreach (partial[i]) word = word * 2 + partial[i];
                partial.delete();
                complete = 1;
            end
        end
        slot_free = !exp_valid || rdy;
        if (complete && slot_free) begin
            exp_data  = word;
            exp_valid = 1;
        end else if (exp_valid && rdy) begin
            exp_valid = 0;
        end
        if (complete && !slot_free) exp_ovr = 1;
        else if (oc)                exp_ovr = 0;
    endtask

    task automatic applyStimulus(input bit s, input bit be, input bit sy,
                                 input bit rdy, input bit oc, input string tag);
        @(negedge clk);
        ser_in    = s;
        bit_en    = be;
        sync      = sy;
        out_ready = rdy;
        ovr_clr   = oc;
        @(posedge clk);
        modelStep(s, be, sy, rdy, oc);
        #1;
        checkAll(tag);
    endtask

    // Send a whole word MSB first; the last bit may use a different ready
    task automatic sendWord(input int unsigned word, input bit rdy_body,
                            input bit rdy_last, input string tag);
        for (int i = WIDTH - 1; i >= 0; i--)
            applyStimulus((word >> i) & 1, 1'b1, 1'b0,
                          (i == 0) ? rdy_last : rdy_body, 1'b0, tag);
    endtask

    task automatic idle(input bit rdy, input bit oc, input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0, rdy, oc, tag);
    endtask

    initial begin
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        checkAll("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic word, consumer always ready
        sendWord('h16, 1'b1, 1'b1, "t1");
        checkOutput("t1_word", out_data, 'h16);
        checkOutput("t1_valid", out_valid, 1);
        idle(1'b1, 1'b0, "t1_drain");
        checkOutput("t1_valid_drop", out_valid, 0);

        // Same word with two idle cycles after every bit
        for (int i = WIDTH - 1; i >= 0; i--) begin
            applyStimulus(('h16 >> i) & 1, 1'b1, 1'b0, 1'b1, 1'b0, "t2_bit");
            repeat (2) applyStimulus($urandom_range(0, 1), 1'b0, 1'b0,
                                     1'b1, 1'b0, "t2_gap");
        end
        checkOutput("t2_word", out_data, 'h16);

        // Backpressure: second word is dropped
        sendWord('h16, 1'b0, 1'b0, "t3_a");
        sendWord('h09, 1'b0, 1'b0, "t3_b");
        checkOutput("t3_kept", out_data, 'h16);
        checkOutput("t3_ovr", overrun, 1);
        idle(1'b1, 1'b0, "t3_drain");
        checkOutput("t3_valid_drop", out_valid, 0);
        checkOutput("t3_ovr_sticky", overrun, 1);
        idle(1'b0, 1'b1, "t3_clr");
        checkOutput("t3_ovr_clr", overrun, 0);

        // Completion on the same edge as a transfer
        sendWord('h16, 1'b0, 1'b0, "t4_a");
        sendWord('h09, 1'b0, 1'b1, "t4_b");
        checkOutput("t4_word", out_data, 'h09);
        checkOutput("t4_valid", out_valid, 1);
        checkOutput("t4_ovr", overrun, 0);
        idle(1'b1, 1'b0, "t4_drain");

        // Sync realign discards three stray bits
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "t5_stray");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "t5_sync");
        for (int i = 3; i >= 0; i--)
            applyStimulus(('h05 >> i) & 1, 1'b1, 1'b0, 1'b1, 1'b0, "t5_bit");
        checkOutput("t5_word", out_data, 'h05);
        idle(1'b1, 1'b0, "t5_drain");

        // Asynchronous reset with a held word and a partial word
        sendWord('h16, 1'b0, 1'b0, "t6_held");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t6_part");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t6_part");
        @(negedge clk);
        bit_en    = 1'b0;
        sync      = 1'b0;
        out_ready = 1'b0;
        ovr_clr   = 1'b0;
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkAll("t6_async");
        checkOutput("t6_data_zero", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        sendWord('h1F, 1'b1, 1'b1, "t6_after");
        checkOutput("t6_word", out_data, 'h1F);

        // Random traffic against the model
        for (int n = 0; n < 400; n++)
            applyStimulus($urandom_range(0, 1),
                          ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 9) == 0),
                          "rand");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vector_count, miscompare_count);
        $finish;
    end

endmodule
